// File: rtl/matrix_loop_ctrl_pkg.sv
// Shared definitions for the two-level (row/column) matrix sweep controller.
package matrix_loop_ctrl_pkg;

  localparam int DEFAULT_SIZE_ADDR = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/matrix_loop_ctrl_loop_counter.sv
// Index counter that counts 0..limit; wrap flags that the current value is the last one.
module loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  assign wrap  = (count_q == limit);
  assign count = count_q;

  // Wrapping is compared against limit, never computed as limit+1, so an
  // all-ones limit cannot overflow.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = wrap ? '0 : (count_q + CNT_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_loop_ctrl.sv
// Row/column sweep controller: issues one read per element, waits for the
// datapath result, strobes a write-back, then advances (i, j).
//
// Handshakes: the read request transfers on a cycle where o_rd_en and
// i_dp_ready are both high; o_rd_en holds until then. i_dp_valid is only
// sampled in WAIT. All outputs are flops or decodes of the state register.
module matrix_loop_ctrl
  import matrix_loop_ctrl_pkg::*;
#(
  parameter int SIZE_ADDR = DEFAULT_SIZE_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_ADDR-1:0] i_num_rows,
  input  logic [SIZE_ADDR-1:0] i_num_cols,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_dp_ready,
  input  logic                 i_dp_valid,
  output logic                 o_busy,
  output logic                 o_rd_en,
  output logic                 o_wr_en,
  output logic [SIZE_ADDR-1:0] o_idx_i,
  output logic [SIZE_ADDR-1:0] o_idx_j,
  output logic                 o_row_done,
  output logic                 o_done,
  output logic [2:0]           o_dbg_state
);

  localparam logic [SIZE_ADDR-1:0] IDX_ONE = {{(SIZE_ADDR-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [SIZE_ADDR-1:0] rows_q, rows_d;
  logic [SIZE_ADDR-1:0] cols_q, cols_d;
  logic                 row_done_q, row_done_d;

  logic                 idx_clr;
  logic                 row_en, col_en;
  logic                 row_wrap, col_wrap;
  logic [SIZE_ADDR-1:0] row_last, col_last;
  logic                 start_ok;

  assign row_last = rows_q - IDX_ONE;
  assign col_last = cols_q - IDX_ONE;
  assign start_ok = (i_num_rows != '0) && (i_num_cols != '0);

  loop_counter #(.W(SIZE_ADDR)) u_cnt_i (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (idx_clr),
    .enable (row_en),
    .limit  (row_last),
    .count  (o_idx_i),
    .wrap   (row_wrap)
  );

  loop_counter #(.W(SIZE_ADDR)) u_cnt_j (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (idx_clr),
    .enable (col_en),
    .limit  (col_last),
    .count  (o_idx_j),
    .wrap   (col_wrap)
  );

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_done_d = 1'b0;
    idx_clr    = 1'b0;
    row_en     = 1'b0;
    col_en     = 1'b0;
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (start_ok) begin
              rows_d  = i_num_rows;
              cols_d  = i_num_cols;
              idx_clr = 1'b1;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_ISSUE: if (i_dp_ready) state_d = ST_WAIT;
        ST_WAIT:  if (i_dp_valid) state_d = ST_WRITE;
        ST_WRITE: begin
          // On the final element both counters hold so the last indices stay visible.
          if (!col_wrap) begin
            col_en  = 1'b1;
            state_d = ST_ISSUE;
          end else if (!row_wrap) begin
            col_en     = 1'b1;
            row_en     = 1'b1;
            row_done_d = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_done_q <= row_done_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_rd_en     = (state_q == ST_ISSUE);
  assign o_wr_en     = (state_q == ST_WRITE);
  assign o_done      = (state_q == ST_DONE);
  assign o_row_done  = row_done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_matrix_loop_ctrl.sv
// Bench for matrix_loop_ctrl: directed scenarios plus randomized sweeps
// checked against an element-list reference model.
module tb_matrix_loop_ctrl;
  import matrix_loop_ctrl_pkg::*;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic [W-1:0] i_num_rows, i_num_cols;
  logic         i_start, i_abort, i_dp_ready, i_dp_valid;
  logic         o_busy, o_rd_en, o_wr_en, o_row_done, o_done;
  logic [W-1:0] o_idx_i, o_idx_j;
  logic [2:0]   o_dbg_state;

  matrix_loop_ctrl #(.SIZE_ADDR(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_num_rows  (i_num_rows),
    .i_num_cols  (i_num_cols),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_dp_ready  (i_dp_ready),
    .i_dp_valid  (i_dp_valid),
    .o_busy      (o_busy),
    .o_rd_en     (o_rd_en),
    .o_wr_en     (o_wr_en),
    .o_idx_i     (o_idx_i),
    .o_idx_j     (o_idx_j),
    .o_row_done  (o_row_done),
    .o_done      (o_done),
    .o_dbg_state (o_dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the ordered list of (i, j) elements still to be written.
  logic [2*W-1:0] exp_q[$];
  int   cur_r = 0, cur_c = 0;
  logic rowdone_exp = 1'b0;
  logic done_exp    = 1'b0;
  int   wr_cnt = 0, rd_cnt = 0, rowdone_cnt = 0, done_cnt = 0, done_cyc = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge, and score against the model.
  task automatic cycle();
    logic [2*W-1:0] idx;
    logic [2*W-1:0] e;
    @(posedge i_clk);
    #1;
    cyc++;
    idx = {o_idx_i, o_idx_j};
    check("row_done", 32'(o_row_done), 32'(rowdone_exp));
    check("done", 32'(o_done), 32'(done_exp));
    if (o_row_done) rowdone_cnt++;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    rowdone_exp = 1'b0;
    done_exp    = 1'b0;
    if (o_rd_en) begin
      rd_cnt++;
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_idx", 32'(idx), 32'(exp_q[0]));
    end
    if (o_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_idx", 32'(idx), 32'(e));
        rowdone_exp = (int'(e[W-1:0]) == cur_c - 1) && (int'(e[2*W-1:W]) < cur_r - 1);
        done_exp    = (exp_q.size() == 0);
      end
    end
  endtask

  task automatic load_model(input int r, input int c);
    exp_q.delete();
    for (int rr = 0; rr < r; rr++)
      for (int cc = 0; cc < c; cc++)
        exp_q.push_back({W'(rr), W'(cc)});
    cur_r = r;
    cur_c = c;
    wr_cnt = 0; rd_cnt = 0; rowdone_cnt = 0; done_cnt = 0;
  endtask

  // mode 0: ready/valid high (with optional stall on the second element's read);
  // mode 1: random ready/valid and random dimension churn while busy.
  task automatic run_sweep(input int r, input int c, input int mode, input int stall);
    int  start_cyc;
    int  stall_left;
    bit  nonzero;
    nonzero    = (r > 0) && (c > 0);
    stall_left = stall;
    load_model(r, c);
    i_num_rows = W'(r);
    i_num_cols = W'(c);
    i_dp_ready = 1'b1;
    i_dp_valid = 1'b1;
    i_start    = 1'b1;
    if (!nonzero) done_exp = 1'b1;
    cycle();
    start_cyc = cyc;
    i_start   = 1'b0;
    if (!nonzero) check("zero_busy", 32'(o_busy), 1);
    for (int k = 1; k < 4000 && done_cnt == 0; k++) begin
      if (mode == 1) begin
        i_dp_ready = ($urandom_range(0, 3) != 0);
        i_dp_valid = ($urandom_range(0, 3) != 0);
        i_num_rows = W'($urandom_range(0, 255));
        i_num_cols = W'($urandom_range(0, 255));
      end else begin
        i_dp_valid = 1'b1;
        i_dp_ready = !(stall_left > 0 && o_rd_en && wr_cnt == 1);
        if (!i_dp_ready) stall_left--;
      end
      if (k == 2) begin
        i_start    = 1'b1;
        i_num_rows = W'(r + 1);
        i_num_cols = W'(c + 2);
      end else begin
        i_start = 1'b0;
      end
      cycle();
    end
    i_start = 1'b0;
    check("done_seen", done_cnt, 1);
    check("wr_count", wr_cnt, r * c);
    check("row_done_count", rowdone_cnt, nonzero ? r - 1 : 0);
    check("model_drained", exp_q.size(), 0);
    if (mode == 0 && nonzero) begin
      check("rd_count", rd_cnt, r * c + stall);
      if (stall == 0) check("latency", done_cyc - start_cyc, 3 * r * c);
    end
    cycle();
    check("idle_busy", 32'(o_busy), 0);
    if (nonzero) check("final_idx", 32'({o_idx_i, o_idx_j}), 32'({W'(r - 1), W'(c - 1)}));
  endtask

  initial begin
    bit reached;
    i_rst_n    = 1'b0;
    i_num_rows = '0;
    i_num_cols = '0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_dp_ready = 1'b0;
    i_dp_valid = 1'b0;
    #2;
    check("reset_outs", 32'({o_busy, o_rd_en, o_wr_en, o_row_done, o_done, o_idx_i, o_idx_j}), 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    cycle();
    check("post_reset_busy", 32'(o_busy), 0);

    run_sweep(2, 3, 0, 0);
    run_sweep(1, 4, 0, 5);
    run_sweep(0, 5, 0, 0);

    // Abort while waiting for the datapath result of element (1,1).
    load_model(3, 3);
    i_num_rows = 8'd3;
    i_num_cols = 8'd3;
    i_dp_ready = 1'b1;
    i_dp_valid = 1'b1;
    i_start    = 1'b1;
    cycle();
    i_start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      reached = o_rd_en && (o_idx_i == 8'd1) && (o_idx_j == 8'd1);
      cycle();
    end
    check("abort_reach", 32'(reached), 1);
    check("abort_in_wait", 32'(o_dbg_state), 32'(ST_WAIT));
    i_abort = 1'b1;
    exp_q.delete();
    cycle();
    i_abort = 1'b0;
    check("abort_busy", 32'(o_busy), 0);
    repeat (10) cycle();
    run_sweep(3, 3, 0, 0);

    // Asynchronous reset in the middle of a sweep at element (0,2).
    load_model(2, 4);
    i_num_rows = 8'd2;
    i_num_cols = 8'd4;
    i_start    = 1'b1;
    cycle();
    i_start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      cycle();
      reached = o_rd_en && (o_idx_i == 8'd0) && (o_idx_j == 8'd2);
    end
    check("rst_reach", 32'(reached), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_outs", 32'({o_busy, o_rd_en, o_wr_en, o_row_done, o_done, o_idx_i, o_idx_j}), 0);
    exp_q.delete();
    rowdone_exp = 1'b0;
    done_exp    = 1'b0;
    #2;
    i_rst_n = 1'b1;
    cycle();
    check("rst_release_busy", 32'(o_busy), 0);
    run_sweep(2, 3, 0, 0);

    // Full-range dimensions.
    run_sweep(255, 1, 0, 0);
    run_sweep(1, 255, 0, 0);

    for (int n = 0; n < 25; n++) begin
      run_sweep(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
